// File: rtl/telem_pkg.sv
// telem_pkg: shared telemetry stack widths, source IDs/indices and arbiter FSM states
package telem_pkg;
  localparam int STACK_W = 48;
  localparam int TS_W = 24;
  localparam logic [7:0] ID_GEIG = 8'h47;
  localparam logic [7:0] ID_PRES = 8'h50;
  localparam logic [7:0] ID_TEMP = 8'h54;
  localparam logic [7:0] ID_GPS = 8'h4E;
  localparam int SRC_GEIG = 0;
  localparam int SRC_PRES = 1;
  localparam int SRC_TEMP = 2;
  localparam int SRC_GPS = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2} state_t;
endpackage

// File: rtl/stack_downlink_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searching from rr_last+1 upward mod N_SRC
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int IW = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [IW-1:0]    rr_last,
  output logic [IW-1:0]    win,
  output logic             any
);
  logic [IW-1:0] idx;
  always_comb begin
    win = '0;
    idx = '0;
    // walk farthest-first so the nearest pending source after rr_last is the last write
    for (int k = N_SRC; k >= 1; k--) begin
      idx = IW'((int'(rr_last) + k) % N_SRC);
      if (pending[idx]) win = idx;
    end
  end
  assign any = |pending;
endmodule

// File: rtl/stack_downlink_arbiter.sv
// stack_downlink_arbiter: holds one stack per sensor source and hands them round-robin
// to the single telemetry sink over a four-phase req/ack handshake with timeout.
module stack_downlink_arbiter
  import telem_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int STACK_W = telem_pkg::STACK_W,
  parameter int TIMEOUT_CYC = 50
) (
  input  logic                     CLK_10HZ,
  input  logic                     RESET,
  input  logic [STACK_W*N_SRC-1:0] SRC_DATA,
  input  logic [N_SRC-1:0]         SRC_VALID,
  output logic [STACK_W-1:0]       OUT_DATA,
  output logic [2:0]               OUT_SRC,
  output logic                     OUT_REQ,
  input  logic                     OUT_ACK,
  input  logic                     OVF_CLR,
  output logic [N_SRC-1:0]         OVERFLOW,
  output logic [7:0]               DROP_COUNT,
  output logic                     BUSY
);
  localparam int IW = $clog2(N_SRC);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  state_t state;
  logic [STACK_W-1:0] hold [N_SRC];
  logic [N_SRC-1:0] pending, pend_nxt, grant;
  logic [IW-1:0] rr_last, win;
  logic any, stay_idle;
  logic [TW-1:0] timer;

  rr_pick #(.N_SRC(N_SRC), .IW(IW)) u_pick (.pending(pending), .rr_last(rr_last), .win(win), .any(any));

  // a grant takes the old stack; a same-cycle valid reloads and keeps pending set
  always_comb begin
    grant = '0;
    grant[win] = state == IDLE && any;
    pend_nxt = (pending & ~grant) | SRC_VALID;
  end
  assign stay_idle = (state == IDLE && !any) || (state == GAP && !OUT_ACK);

  always_ff @(posedge CLK_10HZ or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      pending <= '0;
      for (int i = 0; i < N_SRC; i++) hold[i] <= '0;
      rr_last <= IW'(N_SRC - 1);
      timer <= '0;
      OUT_DATA <= '0;
      OUT_SRC <= '0;
      OUT_REQ <= 1'b0;
      OVERFLOW <= '0;
      DROP_COUNT <= '0;
      BUSY <= 1'b0;
    end else begin
      pending <= pend_nxt;
      OVERFLOW <= (SRC_VALID & pending & ~grant) | (OVF_CLR ? '0 : OVERFLOW);
      BUSY <= |pend_nxt || !stay_idle;
      for (int i = 0; i < N_SRC; i++)
        if (SRC_VALID[i]) hold[i] <= SRC_DATA[i*STACK_W +: STACK_W];
      case (state)
        IDLE: if (any) begin
          OUT_DATA <= hold[win];
          OUT_SRC <= 3'(win);
          rr_last <= win;
          OUT_REQ <= 1'b1;
          timer <= '0;
          state <= REQ;
        end
        REQ: if (OUT_ACK) begin
          OUT_REQ <= 1'b0;
          state <= GAP;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          OUT_REQ <= 1'b0;
          DROP_COUNT <= DROP_COUNT + 8'(DROP_COUNT != 8'hFF);
          state <= GAP;
        end else timer <= timer + 1'b1;
        GAP: if (!OUT_ACK) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_downlink_arbiter.sv
// tb_stack_downlink_arbiter: directed scoreboard bench for the stack downlink arbiter
module tb_stack_downlink_arbiter;
  import telem_pkg::*;
  typedef struct packed {logic [2:0] src; logic [47:0] data;} exp_t;
  logic CLK_10HZ = 0, RESET = 0, OUT_REQ, OUT_ACK = 0, OVF_CLR = 0, BUSY;
  logic [191:0] SRC_DATA = '0;
  logic [3:0] SRC_VALID = '0, OVERFLOW;
  logic [47:0] OUT_DATA;
  logic [2:0] OUT_SRC;
  logic [7:0] DROP_COUNT;
  exp_t q[$];
  int pass_cnt = 0, total_cnt = 0;

  stack_downlink_arbiter dut (
    .CLK_10HZ(CLK_10HZ), .RESET(RESET), .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID),
    .OUT_DATA(OUT_DATA), .OUT_SRC(OUT_SRC), .OUT_REQ(OUT_REQ), .OUT_ACK(OUT_ACK),
    .OVF_CLR(OVF_CLR), .OVERFLOW(OVERFLOW), .DROP_COUNT(DROP_COUNT), .BUSY(BUSY)
  );

  always #5 CLK_10HZ = ~CLK_10HZ;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK_10HZ);
  endtask

  function automatic logic [47:0] stk(input logic [15:0] p, input logic [23:0] ts, input logic [7:0] id);
    return {p, ts, id};
  endfunction

  function automatic logic [191:0] at(input int i, input logic [47:0] s);
    logic [191:0] d = '0;
    d[i*48 +: 48] = s;
    return d;
  endfunction

  task automatic pulse(input logic [3:0] v, input logic [191:0] d);
    SRC_VALID = v;
    SRC_DATA = d;
    step(1);
    SRC_VALID = '0;
  endtask

  task automatic push(input int src, input logic [47:0] d);
    q.push_back('{src: 3'(src), data: d});
  endtask

  task automatic check_grant(input string tag);
    exp_t e;
    e = q.size() != 0 ? q.pop_front() : '{src: 3'd7, data: '1};
    chk({tag, "_data"}, 64'(OUT_DATA), 64'(e.data));
    chk({tag, "_src"}, 64'(OUT_SRC), 64'(e.src));
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!OUT_REQ && n < 100) begin step(1); n++; end
    chk({tag, "_req_seen"}, 64'(OUT_REQ), 64'd1);
  endtask

  task automatic serve(input string tag, input int delay);
    wait_req(tag);
    check_grant(tag);
    step(delay);
    OUT_ACK = 1;
    step(1);
    chk({tag, "_req_fall"}, 64'(OUT_REQ), 64'd0);
    OUT_ACK = 0;
    step(1);
  endtask

  task automatic do_reset();
    RESET = 0;
    step(1);
    RESET = 1;
    step(1);
  endtask

  initial begin
    int cnt;
    logic [47:0] d0, d1, d2, d3;
    step(2);
    chk("rst_req", 64'(OUT_REQ), 0);
    chk("rst_data", 64'(OUT_DATA), 0);
    chk("rst_src", 64'(OUT_SRC), 0);
    chk("rst_ovf", 64'(OVERFLOW), 0);
    chk("rst_drop", 64'(DROP_COUNT), 0);
    chk("rst_busy", 64'(BUSY), 0);
    RESET = 1;
    step(2);
    // single source: valid at edge k, OUT_REQ after k+1
    push(0, 48'h0012_00A3F1_47);
    pulse(4'b0001, at(0, 48'h0012_00A3F1_47));
    chk("single_req_k", 64'(OUT_REQ), 0);
    chk("single_busy_k", 64'(BUSY), 1);
    step(1);
    chk("single_req_k1", 64'(OUT_REQ), 1);
    check_grant("single");
    OUT_ACK = 1;
    step(1);
    chk("single_req_fall", 64'(OUT_REQ), 0);
    chk("single_busy_gap", 64'(BUSY), 1);
    OUT_ACK = 0;
    step(1);
    chk("single_busy_idle", 64'(BUSY), 0);
    // fairness from reset pointer
    do_reset();
    d0 = stk(16'h0100, 24'h000010, ID_GEIG);
    d1 = stk(16'h0101, 24'h000011, ID_PRES);
    d2 = stk(16'h0102, 24'h000012, ID_TEMP);
    d3 = stk(16'h0103, 24'h000013, ID_GPS);
    push(0, d0); push(1, d1); push(2, d2); push(3, d3);
    pulse(4'hF, at(0, d0) | at(1, d1) | at(2, d2) | at(3, d3));
    for (int i = 0; i < 4; i++) serve("fair_a", 0);
    // bring rr_last to 1, then all four again
    push(1, d1);
    pulse(4'b0010, at(1, d1));
    serve("fair_set", 0);
    push(2, d2); push(3, d3); push(0, d0); push(1, d1);
    pulse(4'hF, at(0, d0) | at(1, d1) | at(2, d2) | at(3, d3));
    for (int i = 0; i < 4; i++) serve("fair_b", 0);
    // overflow on source 2 while the sink holds off
    d0 = stk(16'h0200, 24'h000020, ID_GEIG);
    d1 = stk(16'hAAAA, 24'h000021, ID_TEMP);
    d2 = stk(16'hBBBB, 24'h000022, ID_TEMP);
    push(0, d0);
    pulse(4'b0001, at(0, d0));
    step(1);
    pulse(4'b0100, at(2, d1));
    pulse(4'b0100, at(2, d2));
    push(2, d2);
    chk("ovf_set", 64'(OVERFLOW), 64'h4);
    serve("ovf_x", 0);
    serve("ovf_b", 0);
    chk("ovf_hold", 64'(OVERFLOW), 64'h4);
    OVF_CLR = 1;
    step(1);
    OVF_CLR = 0;
    chk("ovf_clr", 64'(OVERFLOW), 0);
    // timeout with a silent sink
    d3 = stk(16'h0300, 24'h000030, ID_GPS);
    push(3, d3);
    pulse(4'b1000, at(3, d3));
    wait_req("tmo");
    check_grant("tmo");
    cnt = 0;
    while (OUT_REQ && cnt < 200) begin step(1); cnt++; end
    chk("tmo_req_cycles", 64'(cnt), 64'd50);
    chk("tmo_drop1", 64'(DROP_COUNT), 1);
    step(1);
    for (int n = 0; n < 255; n++) begin
      pulse(4'b1000, at(3, d3));
      cnt = 0;
      while (!OUT_REQ && cnt < 10) begin step(1); cnt++; end
      while (OUT_REQ && cnt < 100) begin step(1); cnt++; end
      if (cnt >= 100) chk("tmo_loop_bound", 64'(cnt), 64'd52);
      step(1);
    end
    chk("tmo_drop_sat", 64'(DROP_COUNT), 64'd255);
    step(2);
    // valid and grant on source 1 in the same cycle
    d0 = stk(16'h0401, 24'h000040, ID_PRES);
    d1 = stk(16'h0402, 24'h000041, ID_PRES);
    push(1, d0); push(1, d1);
    pulse(4'b0010, at(1, d0));
    pulse(4'b0010, at(1, d1));
    serve("same_1st", 0);
    serve("same_2nd", 0);
    chk("same_ovf", 64'(OVERFLOW), 0);
    // asynchronous reset during REQ
    pulse(4'b0101, at(0, d0) | at(2, d2));
    step(1);
    chk("rreq_req", 64'(OUT_REQ), 1);
    #2 RESET = 0;
    #1;
    chk("rreq_req_low", 64'(OUT_REQ), 0);
    chk("rreq_busy", 64'(BUSY), 0);
    chk("rreq_data", 64'(OUT_DATA), 0);
    chk("rreq_drop", 64'(DROP_COUNT), 0);
    @(negedge CLK_10HZ);
    RESET = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(1); cnt += int'(OUT_REQ); end
    chk("rreq_quiet", 64'(cnt), 0);
    chk("sb_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/stack_downlink_arbiter.md
# stack_downlink_arbiter

Shares the single 48-bit telemetry sink (flash writer / radio framer) among up to N_SRC sensor data-stack producers: the geiger handler, plus the pressure, temperature and GPS handlers. Each producer pulses a one-cycle valid with its stack. The block holds one stack per source, grants pending sources round-robin, and runs a four-phase req/ack handshake with the sink, with a timeout so a dead sink cannot stall the payload. It sits between the sensor handlers and the storage/downlink path in the CLK_10HZ domain.

## Interface
- N_SRC, 4: number of producer ports (2..8).
- STACK_W, 48: data-stack width {payload, 24-bit TIMESTAMP, 8-bit ID}.
- TIMEOUT_CYC, 50: CLK_10HZ cycles (5 s) to wait for OUT_ACK before dropping.

Ports:
- CLK_10HZ  in  1  system 10 Hz clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- SRC_DATA  in  STACK_W*N_SRC  source i occupies bits [i*STACK_W +: STACK_W].
- SRC_VALID  in  N_SRC  one-cycle strobe; SRC_DATA slice is valid in that cycle only.
- OUT_DATA  out  STACK_W  granted stack; held stable while OUT_REQ=1.
- OUT_SRC  out  3  index of granted source.
- OUT_REQ  out  1  request to sink.
- OUT_ACK  in  1  sink acknowledge, four-phase.
- OVF_CLR  in  1  one-cycle pulse; clears OVERFLOW.
- OVERFLOW  out  N_SRC  sticky: source i overwrote an unsent stack.
- DROP_COUNT  out  8  stacks dropped on timeout; saturates at 255.
- BUSY  out  1  high when not in IDLE or when any stack is pending.

## Operation
- Per-source holding register hold[i] (STACK_W) and pending[i] flag.
- SRC_VALID[i]=1 loads hold[i] and sets pending[i].
  - If pending[i] was already set and is not being granted in the same cycle, the new stack overwrites the old one and OVERFLOW[i] is set.
- Same-cycle valid and grant on the same source: the old stack goes out. The new stack is loaded and pending[i] stays 1. No overflow.
- Round-robin pointer rr_last (reset N_SRC-1). Search order is rr_last+1, rr_last+2, … mod N_SRC. The first pending source wins, and rr_last is set to the winner.
- FSM:
  - IDLE: if any pending, load OUT_DATA/OUT_SRC from the winner, clear pending[winner], set OUT_REQ=1, clear timer, go to REQ. Otherwise stay.
  - REQ: if OUT_ACK=1, set OUT_REQ=0 and go to GAP. Else if timer=TIMEOUT_CYC-1, set OUT_REQ=0, increment DROP_COUNT (saturating) and go to GAP. Otherwise increment timer.
  - GAP: wait for OUT_ACK=0, then go to IDLE. OUT_REQ stays 0.
- OUT_ACK high while in IDLE is ignored.
- OVF_CLR clears all OVERFLOW bits. A new overflow in the same cycle wins (bit stays set).
- Reset mid-handshake: everything returns to reset values immediately (asynchronous). The in-flight stack and all pending stacks are discarded.

## Timing
- Reset values:
  - OUT_REQ=0, OUT_DATA=0, OUT_SRC=0.
  - OVERFLOW=0, DROP_COUNT=0, BUSY=0.
  - pending=0, hold=0, state=IDLE, timer=0.
- Latency: SRC_VALID sampled at edge k with FSM idle and no other pending source gives OUT_REQ=1 after edge k+1.
- OUT_REQ falls at the first edge where OUT_ACK=1 is sampled in REQ.
- Minimum grant-to-grant spacing is 3 cycles (IDLE, REQ, GAP).
- Timeout: OUT_REQ is high for exactly TIMEOUT_CYC cycles when OUT_ACK never rises.
- All outputs are registered. There is no combinational path from OUT_ACK or SRC_VALID to any output.
- Timer width is $clog2(TIMEOUT_CYC). TIMEOUT_CYC=1 must still work: the drop happens after one REQ cycle.

## Structure
- Shared package telem_pkg:
  - STACK_W=48 and TS_W=24.
  - Source ID constants: ID_GEIG=8'h47, ID_PRES=8'h50, ID_TEMP=8'h54, ID_GPS=8'h4E.
  - Source index constants: SRC_GEIG=0 … SRC_GPS=3.
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, GAP=2'd2.
- One sub-module, rr_pick: a combinational round-robin picker (inputs pending and rr_last; outputs winner index and any_pending).
- The top level holds the registers, FSM, timer and counters.

## Test plan
- Single source: SRC_VALID[0] with 48'h0012_00A3F1_47 at edge 5, sink acks one cycle after OUT_REQ.
  - Expect OUT_REQ=1 after edge 6, OUT_DATA=48'h001200A3F147, OUT_SRC=0.
  - Expect OUT_REQ=0 after the ack edge and BUSY=0 after GAP.
- Fairness: all 4 sources valid in the same cycle, sink acks immediately.
  - Expect grant order 0,1,2,3.
  - Repeat with rr_last=1: order 2,3,0,1.
- Overflow: source 2 valid twice (A then B) while the sink holds off ack.
  - Expect OVERFLOW=4'b0100, and B (not A) delivered for source 2.
  - OVF_CLR then clears it to 0.
- Timeout: one stack, OUT_ACK tied low.
  - Expect OUT_REQ high for exactly 50 cycles and DROP_COUNT=1.
  - After 256 such drops, DROP_COUNT stays at 255.
- Simultaneous valid and grant on source 1: the first stack is sent, the second is delivered in the next grant, and OVERFLOW[1]=0.
- Reset asserted while in REQ:
  - Expect OUT_REQ=0 and pending=0 asynchronously.
  - After release with no new valids, no request appears for 20 cycles.
